arduino_hit_rx: RTL and testbench

- FPGA-side receiver for the Arduino hit-sensor bus. The Arduino drives a parallel box code, where 0 means no hit and 1..NUM_BOXES identify the struck box.
- The block synchronises, debounces and validates the code, then presents one hit at a time to the game controller with a valid/ack handshake.
- It enforces release-before-rearm, so a held mallet produces exactly one hit.

---
 rtl/bytebasher_pkg.sv | 16 +
 rtl/sync_2ff.sv | 23 ++
 rtl/arduino_hit_rx.sv | 145 ++++++++++++++
 tb/tb_arduino_hit_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bytebasher_pkg.sv
// Shared definitions for the ByteBasher hit-sensor receiver and game controller.
package bytebasher_pkg;

   localparam int BOX_W_DEF     = 4;
   localparam int NUM_BOXES_DEF = 9;

   localparam logic [BOX_W_DEF-1:0] NO_HIT = '0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUAL    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_REARM   = 2'd3
   } hit_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser with asynchronous active-high reset.
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_p0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_p0 <= '0;
         q       <= '0;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/arduino_hit_rx.sv
// Arduino hit-sensor bus receiver: synchronise, debounce, validate, present one hit per press.
// Optional statistics counters are built when HIT_RX_STATS_EN is defined.
module arduino_hit_rx
   import bytebasher_pkg::*;
#(
   parameter int BOX_W         = BOX_W_DEF,
   parameter int NUM_BOXES     = NUM_BOXES_DEF,
   parameter int STABLE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BOX_W-1:0] ard_box_i,
   input  logic             enable,
   output logic             hit_valid,
   output logic [BOX_W-1:0] hit_box,
   input  logic             hit_ack,
`ifdef HIT_RX_STATS_EN
   input  logic             clear_stats,
   output logic [15:0]      hit_count,
   output logic [15:0]      invalid_count,
`endif
   output logic             err_invalid
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_REARM = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [BOX_W-1:0] BOX_NONE  = BOX_W'(NO_HIT);
   localparam logic [BOX_W-1:0] BOX_MAX   = BOX_W'(NUM_BOXES);

   function automatic logic box_legal(input logic [BOX_W-1:0] box);
      return (box != BOX_NONE) && (box <= BOX_MAX);
   endfunction

   logic [BOX_W-1:0] sync_box;
   logic [BOX_W-1:0] candidate;
   logic [CNT_W-1:0] count;
   hit_rx_state_t    state;

   sync_2ff #(
      .WIDTH (BOX_W)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ard_box_i),
      .q     (sync_box)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         count       <= '0;
         candidate   <= '0;
         hit_valid   <= 1'b0;
         hit_box     <= '0;
         err_invalid <= 1'b0;
      end else begin
         err_invalid <= 1'b0;
         // Dropping enable abandons any partial or pending hit, including one acked this cycle.
         if (!enable && (state != ST_REARM)) begin
            state     <= ST_REARM;
            count     <= '0;
            hit_valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (sync_box != BOX_NONE) begin
                     candidate <= sync_box;
                     count     <= CNT_ONE;
                     state     <= ST_QUAL;
                  end
               end
               ST_QUAL: begin
                  if (sync_box == BOX_NONE) begin
                     state <= ST_IDLE;
                  end else if (sync_box != candidate) begin
                     candidate <= sync_box;
                     count     <= CNT_ONE;
                  end else if (count == CNT_FULL) begin
                     count <= '0;
                     if (box_legal(candidate)) begin
                        hit_box   <= candidate;
                        hit_valid <= 1'b1;
                        state     <= ST_PRESENT;
                     end else begin
                        err_invalid <= 1'b1;
                        state       <= ST_REARM;
                     end
                  end else begin
                     count <= count + CNT_ONE;
                  end
               end
               ST_PRESENT: begin
                  if (hit_ack) begin
                     hit_valid <= 1'b0;
                     count     <= '0;
                     state     <= ST_REARM;
                  end
               end
               ST_REARM: begin
                  // The bus must read idle for a full debounce window before the next press counts.
                  if (sync_box != BOX_NONE) begin
                     count <= '0;
                  end else if (count == CNT_REARM) begin
                     count <= '0;
                     state <= ST_IDLE;
                  end else begin
                     count <= count + CNT_ONE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

`ifdef HIT_RX_STATS_EN
   logic hit_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_valid_q   <= 1'b0;
         hit_count     <= '0;
         invalid_count <= '0;
      end else begin
         hit_valid_q <= hit_valid;
         if (clear_stats) begin
            hit_count     <= '0;
            invalid_count <= '0;
         end else begin
            if (hit_valid && !hit_valid_q && (hit_count != 16'hFFFF))
               hit_count <= hit_count + 16'd1;
            if (err_invalid && (invalid_count != 16'hFFFF))
               invalid_count <= invalid_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_arduino_hit_rx.sv
// Directed scoreboard bench for arduino_hit_rx with STABLE_CYCLES=4, NUM_BOXES=9.
module tb_arduino_hit_rx;

   localparam int BOX_W = 4;
   localparam int NUM_BOXES = 9;
   localparam int STABLE_CYCLES = 4;
   localparam int LATENCY = STABLE_CYCLES + 3;

   typedef struct {
      logic [BOX_W-1:0] box;
      int               cyc;
   } hit_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [BOX_W-1:0] ard_box_i = '0;
   logic             enable = 1'b0;
   logic             hit_valid;
   logic [BOX_W-1:0] hit_box;
   logic             hit_ack = 1'b0;
   logic             err_invalid;
`ifdef HIT_RX_STATS_EN
   logic             clear_stats = 1'b0;
   logic [15:0]      hit_count;
   logic [15:0]      invalid_count;
`endif

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   err_seen = 0;
   logic hv_prev = 1'b0;
   hit_t obs_q[$];
   hit_t exp_q[$];

   arduino_hit_rx #(
      .BOX_W         (BOX_W),
      .NUM_BOXES     (NUM_BOXES),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ard_box_i     (ard_box_i),
      .enable        (enable),
      .hit_valid     (hit_valid),
      .hit_box       (hit_box),
      .hit_ack       (hit_ack),
`ifdef HIT_RX_STATS_EN
      .clear_stats   (clear_stats),
      .hit_count     (hit_count),
      .invalid_count (invalid_count),
`endif
      .err_invalid   (err_invalid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (hit_valid && !hv_prev) obs_q.push_back('{box: hit_box, cyc: cyc});
      if (err_invalid) err_seen <= err_seen + 1;
      hv_prev <= hit_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic expect_hit(input logic [BOX_W-1:0] box, input logic timed);
      exp_q.push_back('{box: box, cyc: timed ? cyc + LATENCY : -1});
   endtask

   task automatic wait_hit(input string tag);
      hit_t e;
      hit_t o;
      int   n = 0;
      while ((obs_q.size() == 0) && (n < 40)) begin
         tick();
         n++;
      end
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
         chk({tag, "_timeout"}, obs_q.size(), 1);
      end else begin
         o = obs_q.pop_front();
         chk({tag, "_box"}, o.box, e.box);
         if (e.cyc >= 0) chk({tag, "_latency"}, o.cyc, e.cyc);
         chk({tag, "_held_valid"}, hit_valid, 1'b1);
         chk({tag, "_held_box"}, hit_box, e.box);
      end
   endtask

   task automatic ack_hit(input string tag);
      hit_ack = 1'b1;
      tick();
      hit_ack = 1'b0;
      chk({tag, "_ack_drop"}, hit_valid, 1'b0);
   endtask

   initial begin
      tick(3);
      chk("reset_hit_valid", hit_valid, 1'b0);
      chk("reset_hit_box", hit_box, '0);
      chk("reset_err", err_invalid, 1'b0);
`ifdef HIT_RX_STATS_EN
      chk("reset_hit_count", hit_count, 16'd0);
      chk("reset_invalid_count", invalid_count, 16'd0);
`endif
      enable = 1'b1;
      reset = 1'b0;
      tick(2);

      // basic press with exact latency, then ack
      ard_box_i = 4'd5;
      expect_hit(4'd5, 1'b1);
      wait_hit("press5");
      ack_hit("press5");

      // held mallet and short release must not rearm
      tick(3);
      ard_box_i = 4'd0;
      tick(2);
      ard_box_i = 4'd5;
      tick(12);
      chk("held_no_second_hit", obs_q.size(), 0);
      ard_box_i = 4'd0;
      tick(8);
      hit_ack = 1'b1;
      tick();
      hit_ack = 1'b0;
      chk("idle_ack_ignored", hit_valid, 1'b0);
      ard_box_i = 4'd5;
      expect_hit(4'd5, 1'b1);
      wait_hit("rearmed5");
      ack_hit("rearmed5");
      ard_box_i = 4'd0;
      tick(8);

      // bouncing code never qualifies
      for (int i = 0; i < 4; i++) begin
         ard_box_i = (i % 2 == 0) ? 4'd3 : 4'd0;
         tick(2);
      end
      ard_box_i = 4'd0;
      tick(8);
      chk("bounce_no_hit", obs_q.size(), 0);
      chk("bounce_no_err", err_seen, 0);

      // illegal code flags an error only
      ard_box_i = 4'd12;
      tick(10);
      chk("illegal_err_pulses", err_seen, 1);
      chk("illegal_no_hit", obs_q.size(), 0);
      chk("illegal_hit_valid", hit_valid, 1'b0);
      ard_box_i = 4'd0;
      tick(8);
      ard_box_i = 4'd2;
      expect_hit(4'd2, 1'b1);
      wait_hit("after_illegal2");
      ack_hit("after_illegal2");
      ard_box_i = 4'd0;
      tick(8);

      // enable drop discards a pending hit
      ard_box_i = 4'd7;
      expect_hit(4'd7, 1'b1);
      wait_hit("pending7");
      ard_box_i = 4'd0;
      enable = 1'b0;
      tick();
      chk("disable_drop_valid", hit_valid, 1'b0);
      chk("disable_no_err", err_invalid, 1'b0);
      enable = 1'b1;
      tick(8);
      chk("disable_no_err_total", err_seen, 1);
      ard_box_i = 4'd4;
      expect_hit(4'd4, 1'b1);
      wait_hit("reenabled4");
      ack_hit("reenabled4");
      ard_box_i = 4'd0;
      tick(8);

`ifdef HIT_RX_STATS_EN
      chk("stats_hit_count", hit_count, 16'd5);
      chk("stats_invalid_count", invalid_count, 16'd1);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("stats_clear_hits", hit_count, 16'd0);
      chk("stats_clear_invalid", invalid_count, 16'd0);
`endif

      // reset in QUAL
      ard_box_i = 4'd6;
      tick(4);
      reset = 1'b1;
      #1;
      chk("rst_qual_valid", hit_valid, 1'b0);
      chk("rst_qual_box", hit_box, '0);
      chk("rst_qual_err", err_invalid, 1'b0);
      ard_box_i = 4'd0;
      tick(2);
      reset = 1'b0;
      tick(8);
      chk("rst_qual_no_hit", obs_q.size(), 0);

      // reset in PRESENT
      ard_box_i = 4'd8;
      expect_hit(4'd8, 1'b1);
      wait_hit("present8");
      reset = 1'b1;
      #1;
      chk("rst_present_valid", hit_valid, 1'b0);
      chk("rst_present_box", hit_box, '0);
`ifdef HIT_RX_STATS_EN
      chk("rst_present_hit_count", hit_count, 16'd0);
`endif
      ard_box_i = 4'd0;
      tick(2);
      reset = 1'b0;
      tick(8);
      chk("final_no_extra_hits", obs_q.size(), 0);
      chk("final_no_missing_hits", exp_q.size(), 0);
      chk("final_err_total", err_seen, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
